// File: rtl/issue_ctrl.sv
// IF->ID issue queue: 2**DEPTH_LOG2-entry FIFO; head dispatched when its ROB plus RS/LSB target has room. `define ISSUE_BYPASS_EN for empty-queue bypass.
// Latency: 1 cycle IF->ID minimum (0 cycles with ISSUE_BYPASS_EN and an empty queue).
// Backpressure: if_ready drops when full, flushing, in reset or rdy=0; the head waits while its targets are full.
module issue_ctrl #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  input  logic        rs_full,
  input  logic        lsb_full,
  input  logic        rob_full,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [15:0] stall_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [63:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] head, tail;
  logic [DEPTH_LOG2:0]   count;

  logic        active, not_empty, push, pop, wr, byp, sel_vld;
  logic        is_mem, can_disp, stall_inc;
  logic [31:0] sel_inst, sel_pc;
  logic [63:0] head_ent;

  assign active    = rst && rdy && !flush;
  assign not_empty = (count != '0);
  assign if_ready  = active && (count != CNT_FULL);
  assign push      = if_valid && if_ready;
  assign head_ent  = mem[head];

  // Dispatch candidate: the FIFO head, or the incoming fetch when bypassing an empty queue.
  always_comb begin
    sel_vld  = 1'b0;
    byp      = 1'b0;
    sel_inst = 32'd0;
    sel_pc   = 32'd0;
    if (not_empty) begin
      sel_vld  = 1'b1;
      sel_inst = head_ent[31:0];
      sel_pc   = head_ent[63:32];
    end
`ifdef ISSUE_BYPASS_EN
    else if (push) begin
      sel_vld  = 1'b1;
      byp      = 1'b1;
      sel_inst = if_inst;
      sel_pc   = if_pc;
    end
`endif
  end

  assign is_mem    = (sel_inst[6:0] == 7'b0000011) || (sel_inst[6:0] == 7'b0100011);
  assign can_disp  = !rob_full && (is_mem ? !lsb_full : !rs_full);
  assign id_valid  = active && sel_vld && can_disp;
  assign id_inst   = sel_inst;
  assign id_pc     = sel_pc;
  assign pop       = id_valid && !byp;
  assign wr        = push && !(byp && id_valid);
  assign stall_inc = active && not_empty && !can_disp;

  always_ff @(posedge clk) begin
    if (wr) mem[tail] <= {if_pc, if_inst};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      stall_cnt <= 16'd0;
    end else if (rdy) begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (wr)  tail <= tail + PTR_ONE;
        if (pop) head <= head + PTR_ONE;
        case ({wr, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
      // Flush does not clear the stall statistic.
      if (stall_inc && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
